// File: rtl/sal_dfi_mem_responder_pkg.sv
// Shared types for the DFI memory responder: command set, error codes and
// the pin-level command decoder.
package sal_dfi_mem_responder_pkg;

  localparam int unsigned BEAT_W = 2;  // log2 of beats per column burst

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5,
    CMD_DES = 3'd6
  } dfi_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_CLOSED_BANK = 3'd1,
    ERR_ACT_OPEN    = 3'd2,
    ERR_TCCD        = 3'd3,
    ERR_WRDATA_EN   = 3'd4,
    ERR_REF_OPEN    = 3'd5
  } err_code_e;

  // Unrecognised pin patterns with cs_n low are treated as NOP.
  function automatic dfi_cmd_e dfi_decode(input logic cs_n, input logic ras_n,
                                          input logic cas_n, input logic we_n);
    dfi_cmd_e cmd;
    casez ({cs_n, ras_n, cas_n, we_n})
      4'b1???: cmd = CMD_DES;
      4'b0011: cmd = CMD_ACT;
      4'b0101: cmd = CMD_RD;
      4'b0100: cmd = CMD_WR;
      4'b0010: cmd = CMD_PRE;
      4'b0001: cmd = CMD_REF;
      4'b0111: cmd = CMD_NOP;
      default: cmd = CMD_NOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/sal_dfi_mem_responder_if.sv
// DFI command/data bundle between a controller (master) and the responder (slave).
interface sal_dfi_mem_responder_if #(
  parameter int unsigned BA_W   = 3,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 64
) ();
  logic                  dfi_cs_n;
  logic                  dfi_ras_n;
  logic                  dfi_cas_n;
  logic                  dfi_we_n;
  logic [BA_W-1:0]       dfi_bank;
  logic [ADDR_W-1:0]     dfi_address;
  logic                  dfi_wrdata_en;
  logic [DATA_W-1:0]     dfi_wrdata;
  logic [DATA_W/8-1:0]   dfi_wrdata_mask;
  logic                  dfi_rddata_valid;
  logic [DATA_W-1:0]     dfi_rddata;

  modport master (
    output dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address,
           dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask,
    input  dfi_rddata_valid, dfi_rddata
  );

  modport slave (
    input  dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address,
           dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask,
    output dfi_rddata_valid, dfi_rddata
  );
endinterface

// File: rtl/sal_dfi_mem_responder_lat_pipe.sv
// Fixed-latency delay line carrying a payload with a valid bit.
// A push at edge T is visible on the outputs between edges T+DEPTH-1 and T+DEPTH.
module sal_dfi_lat_pipe #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] vld_r;
  logic [W-1:0]     dat_r [DEPTH];

  // Shift valid and payload one stage per cycle; reset flushes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int i = 0; i < int'(DEPTH); i++) dat_r[i] <= '0;
    end else begin
      vld_r[0] <= in_valid;
      dat_r[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[DEPTH-1];
  assign out_data  = dat_r[DEPTH-1];
endmodule

// File: rtl/sal_dfi_mem_responder.sv
// DFI-side memory stand-in: decodes commands, tracks open banks, stores write
// bursts and returns read bursts at a fixed latency, latching the first
// protocol violation it sees.
module sal_dfi_mem_responder
  import sal_dfi_mem_responder_pkg::*;
#(
  parameter int unsigned BA_W      = 3,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_CYC = 4,
  parameter int unsigned WR_LAT    = 4,
  parameter int unsigned RD_LAT    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sal_dfi_mem_responder_if.slave dfi,
  output logic                  err_o,
  output logic [2:0]            err_code_o
);
  localparam int unsigned NBANK  = 1 << BA_W;
  localparam int unsigned NBYTE  = DATA_W / 8;
  localparam int unsigned BASE_W = BA_W + 5;          // bank, row[1:0], col[5:3]
  localparam int unsigned IDX_W  = BASE_W + BEAT_W;

  dfi_cmd_e           cmd_s;
  err_code_e          err_det_s;
  logic               is_col_s, col_ok_s, rd_push_s, wr_push_s, wr_exp_s, wr_do_s, rd_fire_s;
  logic [BASE_W-1:0]  col_base_s;
  logic               rd_pipe_vld_s, wr_pipe_vld_s;
  logic [BASE_W-1:0]  rd_pipe_base_s, wr_pipe_base_s;
  logic [IDX_W-1:0]   rd_idx_s, wr_idx_s;

  logic [NBANK-1:0]   open_r;
  logic [1:0]         row_lo_r [NBANK];
  logic [2:0]         ccd_cnt_r;          // cycles since last column command, saturates at 7
  logic [1:0]         wr_cnt_r, wr_beat_r, rd_cnt_r, rd_beat_r;
  logic [BASE_W-1:0]  wr_base_r, rd_base_r;
  logic               rd_valid_r, err_r;
  logic [DATA_W-1:0]  rd_data_r;
  err_code_e          err_code_r;
  logic [DATA_W-1:0]  store_r [1 << IDX_W];

  logic unused_addr_s;
  assign unused_addr_s = ^{dfi.dfi_address[ADDR_W-1:11], dfi.dfi_address[9:6], dfi.dfi_address[2]};

  // Classify the sampled command, pick the lowest-numbered error this cycle, and
  // form store indices for the active write and read beats.
  always_comb begin
    cmd_s      = dfi_decode(dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n);
    col_base_s = {dfi.dfi_bank, row_lo_r[dfi.dfi_bank], dfi.dfi_address[5:3]};
    is_col_s   = (cmd_s == CMD_RD) || (cmd_s == CMD_WR);
    col_ok_s   = is_col_s && open_r[dfi.dfi_bank] && (ccd_cnt_r >= 3'd4);
    rd_push_s  = col_ok_s && (cmd_s == CMD_RD);
    wr_push_s  = col_ok_s && (cmd_s == CMD_WR);
    wr_exp_s   = wr_pipe_vld_s || (wr_cnt_r != 2'd0);
    wr_do_s    = wr_exp_s && dfi.dfi_wrdata_en;
    rd_fire_s  = rd_pipe_vld_s || (rd_cnt_r != 2'd0);
    if (wr_pipe_vld_s) begin
      wr_idx_s = {wr_pipe_base_s, 2'b00};
    end else begin
      wr_idx_s = {wr_base_r, wr_beat_r};
    end
    if (rd_pipe_vld_s) begin
      rd_idx_s = {rd_pipe_base_s, 2'b00};
    end else begin
      rd_idx_s = {rd_base_r, rd_beat_r};
    end
    if (is_col_s && !open_r[dfi.dfi_bank]) begin
      err_det_s = ERR_CLOSED_BANK;
    end else if ((cmd_s == CMD_ACT) && open_r[dfi.dfi_bank]) begin
      err_det_s = ERR_ACT_OPEN;
    end else if (is_col_s && (ccd_cnt_r < 3'd4)) begin
      err_det_s = ERR_TCCD;
    end else if (dfi.dfi_wrdata_en != wr_exp_s) begin
      err_det_s = ERR_WRDATA_EN;
    end else if ((cmd_s == CMD_REF) && (|open_r)) begin
      err_det_s = ERR_REF_OPEN;
    end else begin
      err_det_s = ERR_NONE;
    end
  end

  // Bank table: ACT opens (even when already open), PRE closes one bank, PREA closes all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_r <= '0;
      for (int i = 0; i < int'(NBANK); i++) row_lo_r[i] <= 2'b00;
    end else begin
      case (cmd_s)
        CMD_ACT: begin
          open_r[dfi.dfi_bank]   <= 1'b1;
          row_lo_r[dfi.dfi_bank] <= dfi.dfi_address[1:0];
        end
        CMD_PRE: begin
          if (dfi.dfi_address[10]) open_r <= '0;
          else                     open_r[dfi.dfi_bank] <= 1'b0;
        end
        default: open_r <= open_r;
      endcase
    end
  end

  // Column spacing: any column command restarts the count; idle cycles count up to 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ccd_cnt_r <= 3'd7;
    else if (is_col_s)           ccd_cnt_r <= 3'd1;
    else if (ccd_cnt_r != 3'd7)  ccd_cnt_r <= ccd_cnt_r + 3'd1;
    else                         ccd_cnt_r <= ccd_cnt_r;
  end

  // First error wins and is held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
    end else if (!err_r && (err_det_s != ERR_NONE)) begin
      err_r      <= 1'b1;
      err_code_r <= err_det_s;
    end
  end

  sal_dfi_lat_pipe #(.DEPTH(RD_LAT), .W(BASE_W)) u_rd_pipe (
    .clk(clk), .rst_n(rst_n), .in_valid(rd_push_s), .in_data(col_base_s),
    .out_valid(rd_pipe_vld_s), .out_data(rd_pipe_base_s)
  );

  sal_dfi_lat_pipe #(.DEPTH(WR_LAT), .W(BASE_W)) u_wr_pipe (
    .clk(clk), .rst_n(rst_n), .in_valid(wr_push_s), .in_data(col_base_s),
    .out_valid(wr_pipe_vld_s), .out_data(wr_pipe_base_s)
  );

  // Write beat tracker: beat 0 comes straight from the pipe, beats 1..3 from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r <= 2'd0; wr_beat_r <= 2'd0; wr_base_r <= '0;
    end else if (wr_pipe_vld_s) begin
      wr_cnt_r <= 2'(BURST_CYC - 1); wr_beat_r <= 2'd1; wr_base_r <= wr_pipe_base_s;
    end else if (wr_cnt_r != 2'd0) begin
      wr_cnt_r <= wr_cnt_r - 2'd1; wr_beat_r <= wr_beat_r + 2'd1;
    end
  end

  // Byte-masked store update for each accepted write beat; the store is not reset.
  always_ff @(posedge clk) begin
    if (wr_do_s) begin
      for (int b = 0; b < int'(NBYTE); b++) begin
        if (!dfi.dfi_wrdata_mask[b]) store_r[wr_idx_s][8*b +: 8] <= dfi.dfi_wrdata[8*b +: 8];
      end
    end
  end

  // Read beat tracker and registered read data; the store is sampled at pipe exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_r <= 2'd0; rd_beat_r <= 2'd0; rd_base_r <= '0;
      rd_valid_r <= 1'b0; rd_data_r <= '0;
    end else begin
      rd_valid_r <= rd_fire_s;
      rd_data_r  <= rd_fire_s ? store_r[rd_idx_s] : '0;
      if (rd_pipe_vld_s) begin
        rd_cnt_r <= 2'(BURST_CYC - 1); rd_beat_r <= 2'd1; rd_base_r <= rd_pipe_base_s;
      end else if (rd_cnt_r != 2'd0) begin
        rd_cnt_r <= rd_cnt_r - 2'd1; rd_beat_r <= rd_beat_r + 2'd1;
      end
    end
  end

  assign dfi.dfi_rddata_valid = rd_valid_r;
  assign dfi.dfi_rddata       = rd_data_r;
  assign err_o                = err_r;
  assign err_code_o           = err_code_r;
endmodule

// File: tb/tb_sal_dfi_mem_responder.sv
// Directed bench for sal_dfi_mem_responder: a per-cycle vector table for the
// error-free write/read traffic, then short hand sequences for error cases.
module tb_sal_dfi_mem_responder;
  localparam logic [3:0] P_ACT = 4'b0011, P_RD = 4'b0101, P_WR = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010, P_REF = 4'b0001, P_NOP = 4'b0111;
  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111, D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333, D4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA, D5 = 64'h5555_5555_5555_5555;

  typedef struct {
    logic [3:0]  pins;
    logic [2:0]  bank;
    logic [13:0] addr;
    logic        wr_en;
    logic [63:0] wr_data;
    logic [7:0]  wr_mask;
    logic        exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  logic clk, rst_n, err_o;
  logic [2:0] err_code_o;
  int checks = 0, failures = 0;
  vec_t vecs[$];

  sal_dfi_mem_responder_if #(.BA_W(3), .ADDR_W(14), .DATA_W(64)) dfi ();

  sal_dfi_mem_responder #(.BA_W(3), .ADDR_W(14), .DATA_W(64), .BURST_CYC(4),
                          .WR_LAT(4), .RD_LAT(6)) dut (
    .clk(clk), .rst_n(rst_n), .dfi(dfi), .err_o(err_o), .err_code_o(err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic [2:0] b, input logic [13:0] a,
                      input logic en, input logic [63:0] d, input logic [7:0] m,
                      input logic ev, input logic [63:0] ed);
    vec_t v;
    v.pins = p; v.bank = b; v.addr = a; v.wr_en = en; v.wr_data = d; v.wr_mask = m;
    v.exp_valid = ev; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic cmd(input logic [3:0] p, input logic [2:0] b, input logic [13:0] a);
    push(p, b, a, 1'b0, 64'd0, 8'h00, 1'b0, 64'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(P_NOP, 3'd0, 14'd0, 1'b0, 64'd0, 8'h00, 1'b0, 64'd0);
  endtask
  task automatic beat(input logic [63:0] d, input logic [7:0] m);
    push(P_NOP, 3'd0, 14'd0, 1'b1, d, m, 1'b0, 64'd0);
  endtask
  task automatic rexp(input logic [63:0] d);
    push(P_NOP, 3'd0, 14'd0, 1'b0, 64'd0, 8'h00, 1'b1, d);
  endtask

  task automatic drive(input logic [3:0] p, input logic [2:0] b, input logic [13:0] a,
                       input logic en, input logic [63:0] d, input logic [7:0] m);
    {dfi.dfi_cs_n, dfi.dfi_ras_n, dfi.dfi_cas_n, dfi.dfi_we_n} = p;
    dfi.dfi_bank = b; dfi.dfi_address = a;
    dfi.dfi_wrdata_en = en; dfi.dfi_wrdata = d; dfi.dfi_wrdata_mask = m;
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge sample them,
  // and return at the next falling edge with outputs settled.
  task automatic step(input logic [3:0] p, input logic [2:0] b, input logic [13:0] a,
                      input logic en);
    drive(p, b, a, en, 64'd0, 8'h00);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(4'b1111, 3'd0, 14'd0, 1'b0, 64'd0, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seen, first_k, cnt;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, first_k, cnt;
    do_reset();
    chk("reset_valid", 64'(dfi.dfi_rddata_valid), 64'd0);
    chk("reset_data", dfi.dfi_rddata, 64'd0);
    chk("reset_err", 64'(err_o), 64'd0);
    chk("reset_code", 64'(err_code_o), 64'd0);

    // Bank 2 row 5: write 4 beats to col 0x08, read back; then masked overwrite of col 0x10
    // and two reads spaced exactly 4 cycles for a gapless 8-cycle return.
    cmd(P_ACT, 3'd2, 14'd5);          // e0
    idle(1);
    cmd(P_WR, 3'd2, 14'h008);         // e2
    idle(3);
    beat(D1, 8'h00); beat(D2, 8'h00); beat(D3, 8'h00); beat(D4, 8'h00);  // e6..e9
    idle(2);
    cmd(P_RD, 3'd2, 14'h008);         // e12
    idle(5);
    rexp(D1); rexp(D2); rexp(D3); rexp(D4);                              // e18..e21
    cmd(P_WR, 3'd2, 14'h010);         // e22
    idle(3);
    beat(DA, 8'h00); beat(DA, 8'h00); beat(DA, 8'h00); beat(DA, 8'h00);  // e26..e29
    cmd(P_WR, 3'd2, 14'h010);         // e30
    idle(3);
    beat(D5, 8'h0F); beat(D5, 8'hF0); beat(D5, 8'hFF); beat(D5, 8'h00);  // e34..e37
    cmd(P_RD, 3'd2, 14'h010);         // e38
    idle(3);
    cmd(P_RD, 3'd2, 14'h008);         // e42
    idle(1);
    rexp(64'h5555_5555_AAAA_AAAA); rexp(64'hAAAA_AAAA_5555_5555); rexp(DA); rexp(D5);
    rexp(D1); rexp(D2); rexp(D3); rexp(D4);                              // e44..e51
    idle(2);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pins, vecs[i].bank, vecs[i].addr, vecs[i].wr_en,
            vecs[i].wr_data, vecs[i].wr_mask);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(dfi.dfi_rddata_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), dfi.dfi_rddata, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 64'(err_o), 64'd0);
    end

    // Read to a closed bank: flagged, nothing returned.
    do_reset();
    step(P_RD, 3'd1, 14'h000, 1'b0);
    chk("closed_err", 64'(err_o), 64'd1);
    chk("closed_code", 64'(err_code_o), 64'd1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(P_NOP, 3'd0, 14'd0, 1'b0);
      if (dfi.dfi_rddata_valid) seen = 1;
    end
    chk("closed_no_valid", 64'(seen), 64'd0);

    // Reads two cycles apart: second one is dropped, first returns at T+6..T+9.
    do_reset();
    step(P_ACT, 3'd3, 14'd0, 1'b0);
    step(P_NOP, 3'd0, 14'd0, 1'b0);
    step(P_RD, 3'd3, 14'h020, 1'b0);
    step(P_NOP, 3'd0, 14'd0, 1'b0);
    step(P_RD, 3'd3, 14'h028, 1'b0);
    chk("tccd_code", 64'(err_code_o), 64'd3);
    first_k = 0; cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step(P_NOP, 3'd0, 14'd0, 1'b0);
      if (dfi.dfi_rddata_valid) begin
        cnt++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("tccd_first_valid_at", 64'(first_k), 64'd4);
    chk("tccd_valid_cycles", 64'(cnt), 64'd4);

    // Write data enable one cycle early.
    do_reset();
    step(P_ACT, 3'd0, 14'd0, 1'b0);
    step(P_NOP, 3'd0, 14'd0, 1'b0);
    step(P_WR, 3'd0, 14'd0, 1'b0);
    step(P_NOP, 3'd0, 14'd0, 1'b0);
    step(P_NOP, 3'd0, 14'd0, 1'b0);
    chk("wren_ok_before", 64'(err_o), 64'd0);
    step(P_NOP, 3'd0, 14'd0, 1'b1);
    chk("wren_code", 64'(err_code_o), 64'd4);

    // REF with a bank open.
    do_reset();
    step(P_ACT, 3'd4, 14'd0, 1'b0);
    step(P_REF, 3'd0, 14'd0, 1'b0);
    chk("ref_open_code", 64'(err_code_o), 64'd5);

    // ACT, PREA, REF is legal; a second ACT to the reopened bank is not.
    do_reset();
    step(P_ACT, 3'd0, 14'd0, 1'b0);
    step(P_PRE, 3'd0, 14'h400, 1'b0);
    step(P_REF, 3'd0, 14'd0, 1'b0);
    chk("prea_ref_err", 64'(err_o), 64'd0);
    step(P_ACT, 3'd0, 14'd1, 1'b0);
    chk("reopen_err", 64'(err_o), 64'd0);
    step(P_ACT, 3'd0, 14'd2, 1'b0);
    chk("act_open_code", 64'(err_code_o), 64'd2);

    // Async reset in the middle of a read burst.
    step(P_RD, 3'd0, 14'd0, 1'b0);
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      step(P_NOP, 3'd0, 14'd0, 1'b0);
      if (dfi.dfi_rddata_valid) seen = 1;
    end
    chk("midburst_valid_seen", 64'(seen), 64'd1);
    step(P_NOP, 3'd0, 14'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(dfi.dfi_rddata_valid), 64'd0);
    chk("async_data", dfi.dfi_rddata, 64'd0);
    chk("async_err", 64'(err_o), 64'd0);
    chk("async_code", 64'(err_code_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(P_NOP, 3'd0, 14'd0, 1'b0);
    chk("post_reset_valid", 64'(dfi.dfi_rddata_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sal_dfi_mem_responder.md
# sal_dfi_mem_responder

Synthesizable DFI-side responder for the SAL DDR controller: it sits at the DFI end opposite the controller. It decodes DFI control commands, tracks per-bank open rows, and captures write bursts into a small backing store. Read bursts are returned at a fixed latency, and protocol violations are flagged. It is used as the memory/PHY stand-in for controller bring-up in simulation and on FPGA.

## Interface
- BA_W, 3, bank address width
- ADDR_W, 14, DFI address width (row on ACT, column on RD/WR)
- DATA_W, 64, DFI data width per cycle
- BURST_CYC, 4, DFI cycles per column burst (fixed at 4)
- WR_LAT, 4, cycles from WR command to first expected dfi_wrdata_en (1..15)
- RD_LAT, 6, cycles from RD command to first dfi_rddata_valid (2..15)
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n  in  1 each  command pins
- dfi_bank  in  BA_W  bank
- dfi_address  in  ADDR_W  row or column
- dfi_wrdata_en  in  1  write data valid
- dfi_wrdata  in  DATA_W  write data
- dfi_wrdata_mask  in  DATA_W/8  byte mask, 1 = byte not written
- dfi_rddata_valid  out  1  read data valid
- dfi_rddata  out  DATA_W  read data
- err_o  out  1  sticky protocol error
- err_code_o  out  3  code of the first error

## Operation
- Command decode, sampled every cycle, as {cs_n, ras_n, cas_n, we_n}:
  - 0011 = ACT
  - 0101 = RD
  - 0100 = WR
  - 0010 = PRE; address[10]=1 means PREA (all banks)
  - 0001 = REF
  - 0111 = NOP
  - cs_n=1 = deselect
  - any other pattern = ignored
- Bank table: per bank an open flag plus the row's low 2 bits; all banks closed at reset.
  - ACT opens the bank.
  - PRE closes it; PREA closes all banks.
  - REF while any bank is open sets error code 5.
- Store: 2^10 words of DATA_W, not reset. Word index = {bank[2:0], row[1:0], col[5:3], beat[1:0]}.
- RD to an open bank: index base pushed into the read latency pipe; emerges RD_LAT cycles later. Then for 4 consecutive cycles, dfi_rddata = store[base+beat], beat 0..3.
- WR to an open bank: base pushed into the write latency pipe, WR_LAT deep. For 4 cycles starting at T+WR_LAT, dfi_wrdata_en must be 1.
  - Each beat writes the unmasked bytes of dfi_wrdata.
  - Masked bytes retain their old value.
- Errors: the first detected error latches err_code_o and sets err_o. Both hold until reset.
  - 1 = RD/WR to a closed bank
  - 2 = ACT to an open bank
  - 3 = column command within 3 cycles of a previous column command (tCCD < 4)
  - 4 = dfi_wrdata_en low in an expected window, or high outside one
  - 5 = REF with an open bank
- Erroneous RD/WR (code 1 or 3) is dropped: no data returned, no store write. An erroneous ACT still reopens the bank with the new row.
- If two errors occur in the same cycle, the lowest code is latched.

## Timing
- Reset values: dfi_rddata_valid=0, dfi_rddata=0, err_o=0, err_code_o=0, bank table closed, both pipes empty.
- Read latency: RD sampled at edge T → dfi_rddata_valid high in cycles T+RD_LAT .. T+RD_LAT+3. Data is registered, so there is no combinational input→output path.
- Back-to-back RDs spaced exactly 4 cycles produce continuous valid with no bubble.
- Write: beats are accepted in cycles T+WR_LAT .. T+WR_LAT+3.
- Same-address ordering: a RD issued after a WR's final beat returns the new data. A RD whose read window overlaps an earlier WR's data window to the same word returns old data (store reads at pipe exit).
- PRE on the same cycle as a pending write window does not cancel the write; windows are already committed.
- Async reset mid-burst: outputs drop to reset values immediately and pipes are flushed. Store contents are undefined.

## Structure
- Shared package SAL_DDR_PKG gains:
  - the DFI command enum (ACT, RD, WR, PRE, REF, NOP, DES)
  - the 3-bit error-code enum
  - the decode function from the four pins
- One sub-module, sal_dfi_lat_pipe: parameterized delay line (depth, payload width) with valid bit. Instantiated twice, for the read and write pipes.
- The column-spacing counter (saturating 3-bit) and the beat counters live in the top module.

## Test plan
- Reset, ACT b2 row 5, WR b2 col 0x08 at T with WR_LAT=4 and 4 beats of 0x11..,0x22..,0x33..,0x44.. in T+4..T+7, RD at T+10 → valid in T+16..T+19 with the same 4 words; err_o stays 0.
- WR with mask 0x0F on beat 0 over prior data 0xAAAA_AAAA_AAAA_AAAA, writing 0x5555… → readback 0x5555_5555_AAAA_AAAA.
- RD to a closed bank 1 → no dfi_rddata_valid, err_o=1, err_code_o=1.
- RD at T and at T+2 → err_code_o=3; only the first burst is returned.
- WR at T, dfi_wrdata_en asserted at T+3 instead of T+4 → err_code_o=4.
- ACT b0, PREA, REF → no error. Then ACT b0, ACT b0 → err_code_o=2. rst_n pulsed low mid-read burst → valid drops in the same cycle, err_o=0.
